// File: rtl/kands_seq_ctrl_if.sv
// K&S sequencer <-> datapath control bundle.
// Master drives enables/selects; slave supplies opcode, run and flags.
interface kands_seq_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic [3:0]       opcode;
  logic             zero_op;
  logic             neg_op;
  logic             signed_overflow;
  logic             branch;
  logic             pc_enable;
  logic             ir_enable;
  logic             write_reg_enable;
  logic             addr_sel;
  logic             c_sel;
  logic [1:0]       operation;
  logic             flags_reg_enable;
  logic             ram_write_enable;
  logic             halt;
  logic [CNT_W-1:0] retired;

  modport master (
    input  run, opcode, zero_op, neg_op, signed_overflow,
    output branch, pc_enable, ir_enable, write_reg_enable,
    output addr_sel, c_sel, operation, flags_reg_enable,
    output ram_write_enable, halt, retired
  );

  modport slave (
    output run, opcode, zero_op, neg_op, signed_overflow,
    input  branch, pc_enable, ir_enable, write_reg_enable,
    input  addr_sel, c_sel, operation, flags_reg_enable,
    input  ram_write_enable, halt, retired
  );
endinterface

// File: rtl/kands_seq_ctrl.sv
// K&S multi-cycle instruction sequencer.
// Registered Moore controls, latency-aware fetch/load waits.
module kands_seq_ctrl #(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input logic              clk,
  input logic              rst_n,
  kands_seq_ctrl_if.master bus
);
  localparam int WW = $clog2(MEM_LATENCY + 1);
  localparam logic [WW-1:0] LAT = WW'(MEM_LATENCY);

  typedef enum logic [3:0] {
    IDLE, FETCH, LATCH, DECODE, EXEC,
    LOAD_WAIT, LOAD_WB, STORE, BRANCH, HALTED
  } state_t;

  typedef struct packed {
    logic       branch;
    logic       pc_enable;
    logic       ir_enable;
    logic       write_reg_enable;
    logic       addr_sel;
    logic       c_sel;
    logic [1:0] operation;
    logic       flags_reg_enable;
    logic       ram_write_enable;
    logic       halt;
  } ctrl_t;

  state_t           state, nxt;
  ctrl_t            ctrl, ctrl_nxt;
  logic [WW-1:0]    wait_cnt, wait_nxt;
  logic [CNT_W-1:0] retired;
  logic             done;
  logic             inc;
  logic             cond;
  logic [1:0]       alu_op;

  always_comb begin
    cond = 1'b0;
    unique case (bus.opcode)
      4'd8:    cond = 1'b1;
      4'd9:    cond = bus.zero_op;
      4'd10:   cond = !bus.zero_op;
      4'd11:   cond = bus.neg_op;
      4'd12:   cond = !bus.neg_op;
      4'd13:   cond = bus.signed_overflow;
      4'd14:   cond = !bus.signed_overflow;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    alu_op = 2'b00;
    unique case (bus.opcode)
      4'd4:    alu_op = 2'b01;
      4'd5:    alu_op = 2'b10;
      4'd6:    alu_op = 2'b11;
      default: alu_op = 2'b00;
    endcase
  end

  always_comb begin
    nxt      = state;
    wait_nxt = wait_cnt;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.run) begin
          nxt      = FETCH;
          wait_nxt = LAT;
        end
      end
      FETCH: begin
        wait_nxt = wait_cnt - 1'b1;
        if (wait_cnt <= 1) nxt = LATCH;
      end
      LATCH: nxt = DECODE;
      DECODE: begin
        unique case (bus.opcode)
          4'd0: done = 1'b1;
          4'd1: begin
            nxt      = LOAD_WAIT;
            wait_nxt = LAT;
          end
          4'd2:  nxt = STORE;
          4'd3, 4'd4, 4'd5, 4'd6, 4'd7: nxt = EXEC;
          4'd15: nxt = HALTED;
          default: nxt = BRANCH;
        endcase
      end
      EXEC:    done = 1'b1;
      LOAD_WAIT: begin
        wait_nxt = wait_cnt - 1'b1;
        if (wait_cnt <= 1) nxt = LOAD_WB;
      end
      LOAD_WB: done = 1'b1;
      STORE:   done = 1'b1;
      BRANCH:  done = 1'b1;
      HALTED:  nxt = HALTED;
      default: nxt = IDLE;
    endcase
    // run is only honoured at an instruction boundary
    if (done) begin
      nxt = bus.run ? FETCH : IDLE;
      if (bus.run) wait_nxt = LAT;
    end
  end

  assign inc = done || (state != HALTED && nxt == HALTED);

  always_comb begin
    ctrl_nxt = '0;
    unique case (nxt)
      FETCH: ctrl_nxt.addr_sel = 1'b1;
      LATCH: begin
        ctrl_nxt.addr_sel  = 1'b1;
        ctrl_nxt.ir_enable = 1'b1;
        ctrl_nxt.pc_enable = 1'b1;
      end
      EXEC: begin
        ctrl_nxt.write_reg_enable = 1'b1;
        ctrl_nxt.c_sel            = 1'b1;
        ctrl_nxt.operation        = alu_op;
        ctrl_nxt.flags_reg_enable = bus.opcode != 4'd3;
      end
      LOAD_WB: ctrl_nxt.write_reg_enable = 1'b1;
      STORE:   ctrl_nxt.ram_write_enable = 1'b1;
      BRANCH: begin
        ctrl_nxt.branch    = cond;
        ctrl_nxt.pc_enable = cond;
      end
      HALTED:  ctrl_nxt.halt = 1'b1;
      default: ctrl_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      retired  <= '0;
      ctrl     <= '0;
    end else begin
      state    <= nxt;
      wait_cnt <= wait_nxt;
      ctrl     <= ctrl_nxt;
      if (inc) retired <= retired + 1'b1;
    end
  end

  assign bus.branch           = ctrl.branch;
  assign bus.pc_enable        = ctrl.pc_enable;
  assign bus.ir_enable        = ctrl.ir_enable;
  assign bus.write_reg_enable = ctrl.write_reg_enable;
  assign bus.addr_sel         = ctrl.addr_sel;
  assign bus.c_sel            = ctrl.c_sel;
  assign bus.operation        = ctrl.operation;
  assign bus.flags_reg_enable = ctrl.flags_reg_enable;
  assign bus.ram_write_enable = ctrl.ram_write_enable;
  assign bus.halt             = ctrl.halt;
  assign bus.retired          = retired;
endmodule

// File: tb/tb_kands_seq_ctrl.sv
// Bench for kands_seq_ctrl: per-instruction expected control
// schedule derived from cycle counts and opcode rules.
module tb_kands_seq_ctrl;
  localparam int L = 3;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   cnt = 0;
  logic [1:0] alu_tab [16];
  logic [10:0] obs;

  always #5 clk = ~clk;

  kands_seq_ctrl_if #(.CNT_W(W)) bus ();

  kands_seq_ctrl #(.MEM_LATENCY(L), .CNT_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign obs = {bus.branch, bus.pc_enable, bus.ir_enable,
                bus.write_reg_enable, bus.addr_sel, bus.c_sel,
                bus.operation, bus.flags_reg_enable,
                bus.ram_write_enable, bus.halt};

  function automatic logic [10:0] mk(
    input logic br, pc, ir, wr, as, cs,
    input logic [1:0] op,
    input logic fe, rw, hl);
    return {br, pc, ir, wr, as, cs, op, fe, rw, hl};
  endfunction

  task automatic chk(input string tag,
                     input logic [15:0] o,
                     input logic [15:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic idle_chk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_ctrl", 16'(obs), 16'd0);
      chk("idle_retired", 16'(bus.retired), 16'(cnt));
    end
  endtask

  task automatic exec_instr(input logic [3:0] op,
                            input logic z, n, v,
                            input bit drop,
                            input int abort);
    logic [10:0] q[$];
    logic [2:0]  f;
    logic        c;
    int          er;
    bit          aborted;
    aborted = 0;
    f = {v, n, z};
    c = 1'b1;
    if (op >= 4'd9 && op <= 4'd14)
      c = f[(int'(op) - 9) / 2] ^ ~op[0];
    q = {};
    repeat (L) q.push_back(mk(0,0,0,0,1,0,2'b00,0,0,0));
    q.push_back(mk(0,1,1,0,1,0,2'b00,0,0,0));
    q.push_back('0);
    if (op >= 4'd3 && op <= 4'd7)
      q.push_back(mk(0,0,0,1,0,1,alu_tab[op],op != 4'd3,0,0));
    else if (op == 4'd1) begin
      repeat (L) q.push_back('0);
      q.push_back(mk(0,0,0,1,0,0,2'b00,0,0,0));
    end else if (op == 4'd2)
      q.push_back(mk(0,0,0,0,0,0,2'b00,0,1,0));
    else if (op >= 4'd8 && op <= 4'd14)
      q.push_back(mk(c,c,0,0,0,0,2'b00,0,0,0));
    else if (op == 4'd15)
      repeat (25) q.push_back(mk(0,0,0,0,0,0,2'b00,0,0,1));
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk); #1;
      er = (op == 4'd15 && i >= L + 2) ? (cnt + 1) % 16 : cnt;
      chk($sformatf("ctrl op%0d cyc%0d", op, i), 16'(obs), 16'(q[i]));
      chk($sformatf("retired op%0d cyc%0d", op, i),
          16'(bus.retired), 16'(er));
      if (i == 0) begin
        bus.opcode = op;
        bus.zero_op = z;
        bus.neg_op = n;
        bus.signed_overflow = v;
        if (drop) bus.run = 1'b0;
      end
      if (i == abort) begin
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl", 16'(obs), 16'd0);
        chk("async_rst_retired", 16'(bus.retired), 16'd0);
        @(negedge clk) rst_n = 1'b1;
        aborted = 1;
        break;
      end
    end
    cnt = aborted ? 0 : (cnt + 1) % 16;
  endtask

  initial begin
    alu_tab = '{default: 2'b00};
    alu_tab[4] = 2'b01;
    alu_tab[5] = 2'b10;
    alu_tab[6] = 2'b11;
    bus.run = 1'b0;
    bus.opcode = 4'd0;
    bus.zero_op = 1'b0;
    bus.neg_op = 1'b0;
    bus.signed_overflow = 1'b0;
    #12;
    chk("reset_ctrl", 16'(obs), 16'd0);
    chk("reset_retired", 16'(bus.retired), 16'd0);
    @(negedge clk) rst_n = 1'b1;
    idle_chk(10);
    bus.run = 1'b1;
    for (int k = 0; k < 17; k++) exec_instr(4'd0, 0, 0, 0, 0, -1);
    for (int op = 3; op <= 7; op++)
      exec_instr(4'(op), 0, 0, 0, 0, -1);
    exec_instr(4'd1, 0, 0, 0, 0, -1);
    exec_instr(4'd2, 0, 0, 0, 0, -1);
    for (int op = 8; op <= 14; op++)
      for (int fl = 0; fl < 8; fl++)
        exec_instr(4'(op), fl[0], fl[1], fl[2], 0, -1);
    exec_instr(4'd2, 0, 0, 0, 1, -1);
    idle_chk(4);
    bus.run = 1'b1;
    for (int k = 0; k < 40; k++)
      exec_instr(4'($urandom_range(0, 14)), 1'($urandom),
                 1'($urandom), 1'($urandom), 0, -1);
    exec_instr(4'd2, 0, 0, 0, 0, L + 2);
    exec_instr(4'd4, 0, 0, 0, 0, -1);
    exec_instr(4'd15, 0, 0, 0, 0, L + 2 + 22);
    exec_instr(4'd0, 0, 0, 0, 0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
